// File: rtl/multilane_block_lock_fsm_if.sv
// Control/status bus of the multilane block-lock engine: limits and per-lane
// sync-header qualifiers in, lock state, indices and event flags out.
interface multilane_block_lock_fsm_if #(
  parameter int N_LANES       = 20,
  parameter int NB_INDEX      = 7,
  parameter int NB_LOCK_CNT   = 7,
  parameter int NB_WINDOW_CNT = 11
);
  logic                          i_enable;
  logic                          i_valid;
  logic [N_LANES-1:0]            i_signal_ok;
  logic [N_LANES-1:0]            i_sh_valid;
  logic [NB_LOCK_CNT-1:0]        i_lock_limit;
  logic [NB_WINDOW_CNT-1:0]      i_window_len;
  logic [NB_WINDOW_CNT-1:0]      i_invalid_limit;
  logic                          i_clear_lost;
  logic [N_LANES*NB_INDEX-1:0]   o_search_index;
  logic [N_LANES*NB_INDEX-1:0]   o_block_index;
  logic [N_LANES-1:0]            o_block_lock;
  logic [N_LANES-1:0]            o_slip;
  logic [N_LANES-1:0]            o_lock_lost;
  logic                          o_all_locked;

  modport master (
    output i_enable, i_valid, i_signal_ok, i_sh_valid, i_lock_limit,
           i_window_len, i_invalid_limit, i_clear_lost,
    input  o_search_index, o_block_index, o_block_lock, o_slip,
           o_lock_lost, o_all_locked
  );

  modport slave (
    input  i_enable, i_valid, i_signal_ok, i_sh_valid, i_lock_limit,
           i_window_len, i_invalid_limit, i_clear_lost,
    output o_search_index, o_block_index, o_block_lock, o_slip,
           o_lock_lost, o_all_locked
  );
endinterface

// File: rtl/multilane_block_lock_fsm.sv
// N independent 66b sync-header block-lock machines: run-length lock acquisition,
// windowed invalid-count unlock, slip pulses, sticky lock-loss and all-locked.
module multilane_block_lock_fsm #(
  parameter int N_LANES        = 20,
  parameter int NB_CODED_BLOCK = 66,
  parameter int NB_INDEX       = $clog2(NB_CODED_BLOCK),
  parameter int MAX_LOCK_CNT   = 64,
  parameter int MAX_WINDOW     = 1024,
  parameter int NB_LOCK_CNT    = $clog2(MAX_LOCK_CNT + 1),
  parameter int NB_WINDOW_CNT  = $clog2(MAX_WINDOW + 1)
) (
  input logic                       i_clock,
  input logic                       i_reset,
  multilane_block_lock_fsm_if.slave bus
);
  localparam logic [NB_INDEX-1:0] LAST_IDX = NB_INDEX'(NB_CODED_BLOCK - 1);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_e;

  function automatic logic [NB_LOCK_CNT-1:0] lock_floor(input logic [NB_LOCK_CNT-1:0] lim);
    return (lim == '0) ? NB_LOCK_CNT'(1) : lim;
  endfunction

  function automatic logic [NB_WINDOW_CNT-1:0] win_floor(input logic [NB_WINDOW_CNT-1:0] lim);
    return (lim == '0) ? NB_WINDOW_CNT'(1) : lim;
  endfunction

  function automatic logic [NB_LOCK_CNT-1:0] lock_inc(input logic [NB_LOCK_CNT-1:0] cnt);
    return (&cnt) ? cnt : cnt + NB_LOCK_CNT'(1);
  endfunction

  function automatic logic [NB_WINDOW_CNT-1:0] win_inc(input logic [NB_WINDOW_CNT-1:0] cnt,
                                                        input logic inc);
    return (inc && !(&cnt)) ? cnt + NB_WINDOW_CNT'(1) : cnt;
  endfunction

  function automatic logic [NB_INDEX-1:0] next_index(input logic [NB_INDEX-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + NB_INDEX'(1);
  endfunction

  logic                        beat;
  logic [NB_LOCK_CNT-1:0]      lock_lim;
  logic [NB_WINDOW_CNT-1:0]    win_lim;
  logic [NB_WINDOW_CNT-1:0]    inv_lim;
  logic [N_LANES-1:0]          lock_vec;
  logic [N_LANES-1:0]          slip_vec;
  logic [N_LANES-1:0]          lost_vec;
  logic [N_LANES*NB_INDEX-1:0] search_vec;
  logic [N_LANES*NB_INDEX-1:0] block_vec;

  assign beat     = bus.i_enable & bus.i_valid;
  assign lock_lim = lock_floor(bus.i_lock_limit);
  assign win_lim  = win_floor(bus.i_window_len);
  assign inv_lim  = win_floor(bus.i_invalid_limit);

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    state_e                   state_q, state_d;
    logic [NB_LOCK_CNT-1:0]   valid_cnt_q, valid_cnt_d;
    logic [NB_WINDOW_CNT-1:0] win_cnt_q, win_cnt_d, inv_cnt_q, inv_cnt_d;
    logic [NB_WINDOW_CNT-1:0] win_nxt, inv_nxt;
    logic [NB_INDEX-1:0]      search_q, search_d, block_q, block_d;
    logic                     slip_q, slip_d, lost_q, lost_d, lost_set;
    logic                     lock_o;

    always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
        state_q     <= UNLOCKED;
        valid_cnt_q <= '0;
        win_cnt_q   <= '0;
        inv_cnt_q   <= '0;
        search_q    <= '0;
        block_q     <= '0;
        slip_q      <= 1'b0;
        lost_q      <= 1'b0;
      end else begin
        state_q     <= state_d;
        valid_cnt_q <= valid_cnt_d;
        win_cnt_q   <= win_cnt_d;
        inv_cnt_q   <= inv_cnt_d;
        search_q    <= search_d;
        block_q     <= block_d;
        slip_q      <= slip_d;
        lost_q      <= lost_d;
      end
    end

    // Loss of signal overrides everything; otherwise only beats move the machine.
    always_comb begin
      state_d     = state_q;
      valid_cnt_d = valid_cnt_q;
      win_cnt_d   = win_cnt_q;
      inv_cnt_d   = inv_cnt_q;
      search_d    = search_q;
      block_d     = block_q;
      slip_d      = 1'b0;
      lost_set    = 1'b0;
      win_nxt     = win_inc(win_cnt_q, 1'b1);
      inv_nxt     = win_inc(inv_cnt_q, !bus.i_sh_valid[k]);
      if (!bus.i_signal_ok[k]) begin
        state_d     = UNLOCKED;
        valid_cnt_d = '0;
        win_cnt_d   = '0;
        inv_cnt_d   = '0;
        search_d    = '0;
        block_d     = '0;
      end else if (beat) begin
        case (state_q)
          UNLOCKED: begin
            if (!bus.i_sh_valid[k]) begin
              valid_cnt_d = '0;
              search_d    = next_index(search_q);
              slip_d      = 1'b1;
            end else if (lock_inc(valid_cnt_q) >= lock_lim) begin
              state_d     = LOCKED;
              block_d     = search_q;
              valid_cnt_d = '0;
              win_cnt_d   = '0;
              inv_cnt_d   = '0;
            end else begin
              valid_cnt_d = lock_inc(valid_cnt_q);
            end
          end
          LOCKED: begin
            // Unlock is tested first so it wins on the last beat of a window.
            if (inv_nxt >= inv_lim) begin
              state_d     = UNLOCKED;
              lost_set    = 1'b1;
              slip_d      = 1'b1;
              search_d    = next_index(search_q);
              valid_cnt_d = '0;
              win_cnt_d   = '0;
              inv_cnt_d   = '0;
            end else if (win_nxt >= win_lim) begin
              win_cnt_d = '0;
              inv_cnt_d = '0;
            end else begin
              win_cnt_d = win_nxt;
              inv_cnt_d = inv_nxt;
            end
          end
          default: ;
        endcase
      end
      lost_d = lost_set | (lost_q & !bus.i_clear_lost);
    end

    always_comb begin
      lock_o = (state_q == LOCKED);
    end

    assign lock_vec[k]                        = lock_o;
    assign slip_vec[k]                        = slip_q;
    assign lost_vec[k]                        = lost_q;
    assign search_vec[k*NB_INDEX +: NB_INDEX] = search_q;
    assign block_vec[k*NB_INDEX +: NB_INDEX]  = block_q;
  end

  assign bus.o_block_lock   = lock_vec;
  assign bus.o_slip         = slip_vec;
  assign bus.o_lock_lost    = lost_vec;
  assign bus.o_search_index = search_vec;
  assign bus.o_block_index  = block_vec;
  assign bus.o_all_locked   = &lock_vec;
endmodule
